// File: rtl/nand_logic_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit (NAND by default) with valid/ready handshake,
// a two-entry main+skid output buffer, reduction-NAND flag and a drained-beat counter.
//
// state | meaning
// EMPTY | no beat held, out_valid=0
// ONE   | main register holds a beat, skid empty
// TWO   | main and skid both hold beats, in_ready=0
module nand_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_rnand,
    output logic             out_err,
    output logic [CNT_W-1:0] txn_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] new_y;
    logic             new_err;
    logic             new_rnand;
    logic [WIDTH-1:0] skid_y;
    logic             skid_err;
    logic             skid_rnand;
    logic             accept;
    logic             drain;

    // Reserved op codes fall back to NAND and flag the beat.
    always_comb begin
        new_err = 1'b0;
        case (in_op)
            3'b000:  new_y = ~(in_a & in_b);
            3'b001:  new_y = in_a & in_b;
            3'b010:  new_y = ~(in_a | in_b);
            3'b011:  new_y = in_a | in_b;
            3'b100:  new_y = in_a ^ in_b;
            3'b101:  new_y = ~(in_a ^ in_b);
            default: begin
                new_y   = ~(in_a & in_b);
                new_err = 1'b1;
            end
        endcase
        new_rnand = ~&new_y;
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_y      <= '0;
            out_rnand  <= 1'b1;
            out_err    <= 1'b0;
            skid_y     <= '0;
            skid_rnand <= 1'b1;
            skid_err   <= 1'b0;
            txn_cnt    <= '0;
        end else begin
            if (drain) begin
                txn_cnt <= txn_cnt + CNT_W'(1);
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_y     <= new_y;
                        out_rnand <= new_rnand;
                        out_err   <= new_err;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        out_y     <= new_y;
                        out_rnand <= new_rnand;
                        out_err   <= new_err;
                    end else if (accept) begin
                        skid_y     <= new_y;
                        skid_rnand <= new_rnand;
                        skid_err   <= new_err;
                        in_ready   <= 1'b0;
                        state      <= TWO;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        out_y     <= skid_y;
                        out_rnand <= skid_rnand;
                        out_err   <= skid_err;
                        in_ready  <= 1'b1;
                        state     <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
